scroll_rate_ctrl: RTL and testbench

//  Upstream controller for the six-digit HEX message scroller. Generates the scroll

---
 rtl/scroll_rate_ctrl_if.sv | 20 ++
 rtl/scroll_rate_ctrl.sv | 131 +++++++++++++
 tb/tb_scroll_rate_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/scroll_rate_ctrl_if.sv
// Control/status bundle between the scroller front panel and scroll_rate_ctrl.
// master drives switches and button; slave (the controller) drives pos/tick/running.
interface scroll_rate_ctrl_if;
  logic [1:0] speed_sel;
  logic       dir;
  logic       pause_n;
  logic [2:0] pos;
  logic       tick;
  logic       running;

  modport master (
    output speed_sel, dir, pause_n,
    input  pos, tick, running
  );

  modport slave (
    input  speed_sel, dir, pause_n,
    output pos, tick, running
  );
endinterface

// File: rtl/scroll_rate_ctrl.sv
// Scroll rate controller: selectable step period, up/down rotation index,
// debounced run/pause button with phase-preserving pause.
module scroll_rate_ctrl #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned NPOS         = 6,
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  scroll_rate_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(2 * CLK_HZ + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [CW-1:0] PER_1X_M1   = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] PER_2X_M1   = CW'(CLK_HZ / 2 - 1);
  localparam logic [CW-1:0] PER_4X_M1   = CW'(CLK_HZ / 4 - 1);
  localparam logic [CW-1:0] PER_HALF_M1 = CW'(2 * CLK_HZ - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]    POS_LAST    = 3'(NPOS - 1);

  typedef enum logic {S_RUN = 1'b0, S_PAUSE = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_pos;
  logic          r_tick;
  logic          r_running;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db_level;
  logic [DW-1:0] r_db_cnt;

  logic [CW-1:0] w_per_m1;
  logic [2:0]    w_pos_next;
  logic          w_terminal;
  logic          w_db_load;
  logic          w_press;

  // Period decode, re-evaluated every cycle so a speed change acts immediately
  always_comb begin
    w_per_m1 = PER_1X_M1;
    case (bus.speed_sel)
      2'b00: w_per_m1 = PER_1X_M1;
      2'b01: w_per_m1 = PER_2X_M1;
      2'b10: w_per_m1 = PER_4X_M1;
      2'b11: w_per_m1 = PER_HALF_M1;
      default: w_per_m1 = PER_1X_M1;
    endcase
  end

  always_comb begin
    w_pos_next = r_pos;
    if (bus.dir) begin
      w_pos_next = (r_pos == 3'd0) ? POS_LAST : r_pos - 3'd1;
    end else begin
      w_pos_next = (r_pos == POS_LAST) ? 3'd0 : r_pos + 3'd1;
    end
  end

  // ">=" lets a shortened period fire on the next edge instead of wrapping the counter
  assign w_terminal = (r_cnt >= w_per_m1);
  assign w_db_load  = (r_sync2 != r_db_level) && (r_db_cnt == DB_LAST);
  assign w_press    = w_db_load && !r_sync2;

  // Button synchronizer and debouncer; level only moves after a full stable window
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_sync1 <= bus.pause_n;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (w_db_load) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end
  end

  // Run/pause FSM with rate counter; pause freezes count so the phase survives
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_pos     <= 3'd0;
      r_tick    <= 1'b0;
      r_running <= 1'b1;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (w_terminal) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_pos  <= w_pos_next;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (w_press) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (w_press) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_RUN;
          r_running <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pos     = r_pos;
  assign bus.tick    = r_tick;
  assign bus.running = r_running;

endmodule

// File: tb/tb_scroll_rate_ctrl.sv
// Directed bench for scroll_rate_ctrl with CLK_HZ=8, NPOS=6, DEBOUNCE_CYC=4.
// Inputs change and outputs are sampled on the falling edge; each loop step is one rising edge.
module tb_scroll_rate_ctrl;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  scroll_rate_ctrl_if bus ();

  scroll_rate_ctrl #(
    .CLK_HZ       (8),
    .NPOS         (6),
    .DEBOUNCE_CYC (4)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    resetn        = 1'b1;
    bus.speed_sel = 2'b00;
    bus.dir       = 1'b0;
    bus.pause_n   = 1'b1;
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.pos, bus.tick, bus.running} !== {3'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_async got %b exp %b", {bus.pos, bus.tick, bus.running}, {3'd0, 1'b0, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.pos, bus.tick, bus.running} !== {3'd0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL reset_hold c%0d got %b exp %b", i, {bus.pos, bus.tick, bus.running}, {3'd0, 1'b0, 1'b1});
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_increment();
    logic [4:0] exp;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      exp = {3'((i / 8) % 6), (i % 8 == 0), 1'b1};
      n_cmp++;
      if ({bus.pos, bus.tick, bus.running} !== exp) begin
        n_err++;
        $display("FAIL increment c%0d got %b exp %b", i, {bus.pos, bus.tick, bus.running}, exp);
      end
    end
  endtask

  task automatic test_direction();
    logic [4:0] exp;
    bus.dir = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      exp = {3'((6 - i / 8) % 6), (i % 8 == 0), 1'b1};
      n_cmp++;
      if ({bus.pos, bus.tick, bus.running} !== exp) begin
        n_err++;
        $display("FAIL dir_down c%0d got %b exp %b", i, {bus.pos, bus.tick, bus.running}, exp);
      end
    end
    bus.speed_sel = 2'b10;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      exp = {3'(3 - i / 2), (i % 2 == 0), 1'b1};
      n_cmp++;
      if ({bus.pos, bus.tick, bus.running} !== exp) begin
        n_err++;
        $display("FAIL dir_fast c%0d got %b exp %b", i, {bus.pos, bus.tick, bus.running}, exp);
      end
    end
  endtask

  task automatic test_speed_change();
    logic [4:0] exp;
    logic [2:0] p;
    bus.dir       = 1'b0;
    bus.speed_sel = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      if (i == 6) bus.speed_sel = 2'b10;
      @(negedge clk);
      p   = (i < 6) ? 3'd0 : (i < 8) ? 3'd1 : (i < 10) ? 3'd2 : 3'd3;
      exp = {p, (i == 6 || i == 8 || i == 10), 1'b1};
      n_cmp++;
      if ({bus.pos, bus.tick, bus.running} !== exp) begin
        n_err++;
        $display("FAIL speed_change c%0d got %b exp %b", i, {bus.pos, bus.tick, bus.running}, exp);
      end
    end
  endtask

  task automatic test_pause();
    logic [4:0] exp;
    logic [2:0] p;
    logic       run;
    bus.speed_sel = 2'b00;
    for (int i = 1; i <= 40; i++) begin
      bus.pause_n = ((i >= 1 && i <= 10) || (i >= 21 && i <= 30)) ? 1'b0 : 1'b1;
      @(negedge clk);
      run = (i < 6) ? 1'b1 : (i < 26) ? 1'b0 : 1'b1;
      p   = (i < 28) ? 3'd3 : (i < 36) ? 3'd4 : 3'd5;
      exp = {p, (i == 28 || i == 36), run};
      n_cmp++;
      if ({bus.pos, bus.tick, bus.running} !== exp) begin
        n_err++;
        $display("FAIL pause_resume c%0d got %b exp %b", i, {bus.pos, bus.tick, bus.running}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [4:0] exp;
    logic [2:0] p;
    for (int i = 1; i <= 12; i++) begin
      bus.pause_n = (i <= 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      p   = (i < 4) ? 3'd5 : (i < 12) ? 3'd0 : 3'd1;
      exp = {p, (i == 4 || i == 12), 1'b1};
      n_cmp++;
      if ({bus.pos, bus.tick, bus.running} !== exp) begin
        n_err++;
        $display("FAIL glitch c%0d got %b exp %b", i, {bus.pos, bus.tick, bus.running}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_pause();
    logic [4:0] exp;
    logic [2:0] p;
    for (int i = 1; i <= 13; i++) begin
      bus.speed_sel = (i <= 6) ? 2'b10 : 2'b00;
      bus.pause_n   = (i >= 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      p   = (i < 2) ? 3'd1 : (i < 4) ? 3'd2 : (i < 6) ? 3'd3 : 3'd4;
      exp = {p, (i == 2 || i == 4 || i == 6), (i < 11)};
      n_cmp++;
      if ({bus.pos, bus.tick, bus.running} !== exp) begin
        n_err++;
        $display("FAIL pre_reset c%0d got %b exp %b", i, {bus.pos, bus.tick, bus.running}, exp);
      end
    end
    resetn      = 1'b0;
    bus.pause_n = 1'b1;
    #1;
    n_cmp++;
    if ({bus.pos, bus.tick, bus.running} !== {3'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid got %b exp %b", {bus.pos, bus.tick, bus.running}, {3'd0, 1'b0, 1'b1});
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_press_on_tick();
    logic [4:0] exp;
    for (int i = 1; i <= 20; i++) begin
      bus.pause_n = (i >= 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp = {(i < 8) ? 3'd0 : 3'd1, (i == 8), (i < 8)};
      n_cmp++;
      if ({bus.pos, bus.tick, bus.running} !== exp) begin
        n_err++;
        $display("FAIL press_on_tick c%0d got %b exp %b", i, {bus.pos, bus.tick, bus.running}, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_increment();
    test_direction();
    test_speed_change();
    test_pause();
    test_glitch();
    test_reset_mid_pause();
    test_press_on_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
